// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and bit-level CRC helpers for the Ethernet receive checker.
package eth_pkg;

  localparam logic [31:0] CRC_POLY_REFL   = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'h38FB2284;

  localparam int unsigned ETH_MIN_BYTES = 64;
  localparam int unsigned ETH_MAX_BYTES = 1522;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_e;

  // One reflected LFSR step for a single serial input bit.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic bit_in);
    logic fb;
    fb = crc[0] ^ bit_in;
    return fb ? ((crc >> 1) ^ CRC_POLY_REFL) : (crc >> 1);
  endfunction

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_nbit.sv
// CRC-32 engine consuming DATA_W bits per enabled cycle, LSB first.
module crc32_nbit
  import eth_pkg::*;
#(
  parameter int unsigned DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [31:0]       crc_out_c
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Restart wins so the register is clean for a frame starting on the next cycle.
  always_comb begin
    crc_d = crc_q;
    if (restart) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      for (int i = 0; i < int'(DATA_W); i++) crc_d = crc_step(crc_d, din[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end

  assign crc_out_c = ~bit_rev32(crc_q);

endmodule

// File: rtl/fcs_frame_checker.sv
// Receive-path frame checker: CRC-32, length and alignment verdict per frame.
// Optional good/bad frame counters are built when STATS_EN is defined.
module fcs_frame_checker
  import eth_pkg::*;
#(
  parameter int unsigned DATA_W    = 2,
  parameter int unsigned MIN_BYTES = ETH_MIN_BYTES,
  parameter int unsigned MAX_BYTES = ETH_MAX_BYTES,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axiiv,
  input  logic [DATA_W-1:0] axiid,
  output logic              done,
  output logic              kill,
  output logic              len_err,
  output logic              align_err,
  output logic [15:0]       frame_bytes,
  input  logic              clr_counts,
  output logic [CNT_W-1:0]  good_count,
  output logic [CNT_W-1:0]  bad_count
);

  localparam int unsigned SYM_W   = 32;
  localparam int unsigned PROD_W  = SYM_W + 4;
  localparam int unsigned BYTES_W = PROD_W - 3;

  fsm_state_e         state_q, state_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic               done_q, done_d;
  logic               kill_q, kill_d;
  logic               len_err_q, len_err_d;
  logic               align_err_q, align_err_d;
  logic [15:0]        frame_bytes_q, frame_bytes_d;

  logic               frame_start_c;
  logic               frame_end_c;
  logic [PROD_W-1:0]  bits_c;
  logic [BYTES_W-1:0] bytes_c;
  logic               len_bad_c;
  logic               align_bad_c;
  logic               crc_bad_c;
  logic [31:0]        crc_out_c;

  crc32_nbit #(.DATA_W(DATA_W)) u_crc (
    .clk       (clk),
    .rst       (rst),
    .restart   (frame_end_c),
    .en        (axiiv),
    .din       (axiid),
    .crc_out_c (crc_out_c)
  );

  assign frame_start_c = (state_q == IDLE) && axiiv;
  assign frame_end_c   = (state_q == RUN) && !axiiv;

  // Length is judged on the unsaturated byte count; only the reported value saturates.
  assign bits_c      = PROD_W'(sym_q) * PROD_W'(DATA_W);
  assign bytes_c     = bits_c[PROD_W-1:3];
  assign align_bad_c = |bits_c[2:0];
  assign len_bad_c   = (bytes_c < BYTES_W'(MIN_BYTES)) || (bytes_c > BYTES_W'(MAX_BYTES));
  assign crc_bad_c   = (crc_out_c != ETH_CRC_RESIDUE);

  always_comb begin
    state_d       = state_q;
    sym_d         = sym_q;
    done_d        = done_q;
    kill_d        = kill_q;
    len_err_d     = len_err_q;
    align_err_d   = align_err_q;
    frame_bytes_d = frame_bytes_q;

    case (state_q)
      IDLE:    if (axiiv)  state_d = RUN;
      RUN:     if (!axiiv) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (axiiv) begin
      if (sym_q != '1) sym_d = sym_q + SYM_W'(1);
    end else if (frame_end_c) begin
      sym_d = '0;
    end

    if (frame_start_c) begin
      done_d      = 1'b0;
      kill_d      = 1'b0;
      len_err_d   = 1'b0;
      align_err_d = 1'b0;
    end else if (frame_end_c) begin
      done_d        = 1'b1;
      kill_d        = crc_bad_c | len_bad_c | align_bad_c;
      len_err_d     = len_bad_c;
      align_err_d   = align_bad_c;
      frame_bytes_d = (|bytes_c[BYTES_W-1:16]) ? 16'hFFFF : bytes_c[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sym_q         <= '0;
      done_q        <= 1'b0;
      kill_q        <= 1'b0;
      len_err_q     <= 1'b0;
      align_err_q   <= 1'b0;
      frame_bytes_q <= '0;
    end else begin
      state_q       <= state_d;
      sym_q         <= sym_d;
      done_q        <= done_d;
      kill_q        <= kill_d;
      len_err_q     <= len_err_d;
      align_err_q   <= align_err_d;
      frame_bytes_q <= frame_bytes_d;
    end
  end

  assign done        = done_q;
  assign kill        = kill_q;
  assign len_err     = len_err_q;
  assign align_err   = align_err_q;
  assign frame_bytes = frame_bytes_q;

`ifdef STATS_EN
  logic [CNT_W-1:0] good_count_q, good_count_d;
  logic [CNT_W-1:0] bad_count_q, bad_count_d;
  logic             frame_kill_c;

  assign frame_kill_c = crc_bad_c | len_bad_c | align_bad_c;

  // Clear beats a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    good_count_d = good_count_q;
    bad_count_d  = bad_count_q;
    if (clr_counts) begin
      good_count_d = '0;
      bad_count_d  = '0;
    end else if (frame_end_c) begin
      if (frame_kill_c) begin
        if (bad_count_q != '1) bad_count_d = bad_count_q + CNT_W'(1);
      end else begin
        if (good_count_q != '1) good_count_d = good_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_count_q <= '0;
      bad_count_q  <= '0;
    end else begin
      good_count_q <= good_count_d;
      bad_count_q  <= bad_count_d;
    end
  end

  assign good_count = good_count_q;
  assign bad_count  = bad_count_q;
`else
  logic stats_unused_c;
  assign stats_unused_c = clr_counts;
  assign good_count     = '0;
  assign bad_count      = '0;
`endif

endmodule
